// File: rtl/pwm_carrier_sequencer.sv
// Shared PWM carrier: half-period counter, phase flag, double-buffered period,
// external carrier sync and the common output-enable sequencer.
module pwm_carrier_sequencer #(
  parameter logic [15:0] MIN_PERIOD   = 16'd100,
  parameter logic [15:0] MAX_PERIOD   = 16'h7FFF,
  parameter logic [15:0] RESET_PERIOD = 16'd1000,
  parameter bit          SYNC_ENABLE  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] next_period_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        fault_i,
  input  logic        fault_clear_i,
  input  logic        ext_sync_i,
  output logic [15:0] local_counter_o,
  output logic [15:0] current_period_o,
  output logic [15:0] next_period_o,
  output logic        sync_phase_o,
  output logic        period_start_o,
  output logic        enable_output_o,
  output logic        fault_latched_o,
  output logic [2:0]  state_o
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = 3'd0,
    S_ARMING   = 3'd1,
    S_RUN      = 3'd2,
    S_STOPPING = 3'd3,
    S_FAULT    = 3'd4
  } state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_period_q, cur_period_d;
  logic [CNT_W-1:0] next_period_q, next_period_d;
  logic             phase_q, phase_d;
  logic             pstart_q, pstart_d;
  logic             enable_q, enable_d;
  logic             fault_q, fault_d;
  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic             sync_edge_q, sync_edge_d;

  logic             wrap;
  logic             boundary;

  // Requested period is clamped once here so every consumer sees a legal value.
  always_comb begin
    next_period_d = next_period_i;
    if (next_period_i < MIN_PERIOD) begin
      next_period_d = MIN_PERIOD;
    end else if (next_period_i > MAX_PERIOD) begin
      next_period_d = MAX_PERIOD;
    end
  end

  // Two-flop synchroniser plus registered rising-edge detect on stage 2.
  always_comb begin
    sync1_d     = ext_sync_i & SYNC_ENABLE;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    sync_edge_d = sync2_q & ~sync3_q;
  end

  assign wrap     = (cnt_q == (cur_period_q - CNT_W'(1)));
  assign boundary = (wrap & phase_q) | sync_edge_q;

  // Carrier: the period is only reloaded on a full-period boundary.
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    phase_d      = phase_q;
    cur_period_d = cur_period_q;
    pstart_d     = 1'b0;
    if (boundary) begin
      cnt_d        = '0;
      phase_d      = 1'b0;
      cur_period_d = next_period_q;
      pstart_d     = 1'b1;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Enable sequencer; fault overrides every other input.
  always_comb begin
    state_d = state_q;
    if (fault_i) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !stop_i) state_d = S_ARMING;
        end
        S_ARMING: begin
          if (stop_i) begin
            state_d = S_IDLE;
          end else if (boundary) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (stop_i) state_d = S_STOPPING;
        end
        S_STOPPING: begin
          if (boundary) state_d = S_IDLE;
        end
        S_FAULT: begin
          if (fault_clear_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    enable_d = (state_d == S_RUN) || (state_d == S_STOPPING);
    fault_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      phase_q       <= 1'b0;
      cur_period_q  <= RESET_PERIOD;
      next_period_q <= RESET_PERIOD;
      pstart_q      <= 1'b0;
      enable_q      <= 1'b0;
      fault_q       <= 1'b0;
      state_q       <= S_IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      sync_edge_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      cur_period_q  <= cur_period_d;
      next_period_q <= next_period_d;
      pstart_q      <= pstart_d;
      enable_q      <= enable_d;
      fault_q       <= fault_d;
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      sync_edge_q   <= sync_edge_d;
    end
  end

  assign local_counter_o  = cnt_q;
  assign current_period_o = cur_period_q;
  assign next_period_o    = next_period_q;
  assign sync_phase_o     = phase_q;
  assign period_start_o   = pstart_q;
  assign enable_output_o  = enable_q;
  assign fault_latched_o  = fault_q;
  assign state_o          = state_q;

endmodule
